// File: rtl/timer_sequencer.sv
// Multi-phase pulse scheduler: one shared prescaled countdown steps through up to
// NPHASE programmed durations, drives a per-phase pattern and repeats the sequence.
module timer_sequencer #(
   parameter int NPHASE = 4,
   parameter int CW     = 32,
   parameter int PW     = 16,
   parameter int OW     = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic                 abort,
   input  logic [PW-1:0]        prescale,
   input  logic [NPHASE*CW-1:0] dur_flat,
   input  logic [NPHASE*OW-1:0] pattern_flat,
   input  logic [1:0]           last_phase,
   input  logic [15:0]          repeats,
   output logic                 busy,
   output logic [1:0]           phase,
   output logic [OW-1:0]        out_pattern,
   output logic                 phase_strobe,
   output logic                 done,
   output logic [15:0]          passes_done
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};

   state_t        state_q;
   logic [PW-1:0] pre_cfg_q;
   logic [PW-1:0] pre_cnt_q;
   logic [CW-1:0] timer_q;
   logic [CW-1:0] dur_q [NPHASE];
   logic [OW-1:0] pat_q [NPHASE];
   logic [1:0]    last_q;
   logic [15:0]   rep_q;
   logic          busy_q;
   logic [1:0]    phase_q;
   logic [OW-1:0] pat_out_q;
   logic          strobe_q;
   logic          done_q;
   logic [15:0]   passes_q;

   logic          tick_s;
   logic [1:0]    phase_d;
   logic [15:0]   passes_d;
   logic          cont_s;

   // A zero duration is promoted to one tick so every phase has a visible length.
   function automatic logic [CW-1:0] clamp_dur(input logic [CW-1:0] d);
      clamp_dur = (d == {CW{1'b0}}) ? ONE_C : d;
   endfunction

   // Tick, next phase index, saturated pass count and repeat decision.
   always_comb begin
      tick_s   = (pre_cnt_q == pre_cfg_q);
      phase_d  = phase_q + 2'd1;
      passes_d = (passes_q == 16'hFFFF) ? 16'hFFFF : passes_q + 16'd1;
      cont_s   = (rep_q == 16'd0) || (passes_d < rep_q);
   end

   // Sequencer state, latched configuration, countdown and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         pre_cfg_q <= {PW{1'b0}};
         pre_cnt_q <= {PW{1'b0}};
         timer_q   <= {CW{1'b0}};
         last_q    <= 2'd0;
         rep_q     <= 16'd0;
         busy_q    <= 1'b0;
         phase_q   <= 2'd0;
         pat_out_q <= {OW{1'b0}};
         strobe_q  <= 1'b0;
         done_q    <= 1'b0;
         passes_q  <= 16'd0;
         for (int k = 0; k < NPHASE; k++) begin
            dur_q[k] <= {CW{1'b0}};
            pat_q[k] <= {OW{1'b0}};
         end
      end else begin
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
         if (abort) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            phase_q   <= 2'd0;
            pat_out_q <= {OW{1'b0}};
            pre_cnt_q <= {PW{1'b0}};
            timer_q   <= {CW{1'b0}};
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     pre_cfg_q <= prescale;
                     last_q    <= last_phase;
                     rep_q     <= repeats;
                     for (int k = 0; k < NPHASE; k++) begin
                        dur_q[k] <= dur_flat[k*CW +: CW];
                        pat_q[k] <= pattern_flat[k*OW +: OW];
                     end
                     state_q   <= RUN;
                     busy_q    <= 1'b1;
                     phase_q   <= 2'd0;
                     pat_out_q <= pattern_flat[OW-1:0];
                     strobe_q  <= 1'b1;
                     passes_q  <= 16'd0;
                     pre_cnt_q <= {PW{1'b0}};
                     timer_q   <= clamp_dur(dur_flat[CW-1:0]);
                  end
               end
               RUN: begin
                  if (!tick_s) begin
                     pre_cnt_q <= pre_cnt_q + {{(PW-1){1'b0}}, 1'b1};
                  end else begin
                     pre_cnt_q <= {PW{1'b0}};
                     if (timer_q != ONE_C) begin
                        timer_q <= timer_q - ONE_C;
                     end else if (phase_q != last_q) begin
                        phase_q   <= phase_d;
                        timer_q   <= clamp_dur(dur_q[phase_d]);
                        pat_out_q <= pat_q[phase_d];
                        strobe_q  <= 1'b1;
                     end else begin
                        passes_q <= passes_d;
                        if (cont_s) begin
                           phase_q   <= 2'd0;
                           timer_q   <= clamp_dur(dur_q[0]);
                           pat_out_q <= pat_q[0];
                           strobe_q  <= 1'b1;
                        end else begin
                           state_q   <= IDLE;
                           busy_q    <= 1'b0;
                           phase_q   <= 2'd0;
                           pat_out_q <= {OW{1'b0}};
                           timer_q   <= {CW{1'b0}};
                           done_q    <= 1'b1;
                        end
                     end
                  end
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy         = busy_q;
   assign phase        = phase_q;
   assign out_pattern  = pat_out_q;
   assign phase_strobe = strobe_q;
   assign done         = done_q;
   assign passes_done  = passes_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: directed scenarios plus randomized sequences, all checked
// every cycle against a phase-length model (cycles per phase = max(dur,1)*(prescale+1)).
module tb_timer_sequencer;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start;
   logic          abort;
   logic [15:0]   prescale;
   logic [127:0]  dur_flat;
   logic [31:0]   pattern_flat;
   logic [1:0]    last_phase;
   logic [15:0]   repeats;
   logic          busy;
   logic [1:0]    phase;
   logic [7:0]    out_pattern;
   logic          phase_strobe;
   logic          done;
   logic [15:0]   passes_done;

   int checks   = 0;
   int failures = 0;

   // reference model state
   bit          m_busy;
   int          m_phase;
   longint      m_left;
   int          m_passes;
   bit          m_strobe;
   bit          m_done;
   int          m_pre;
   int          m_last;
   int          m_rep;
   longint      m_dur [4];
   logic [7:0]  m_pat [4];

   timer_sequencer dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort),
      .prescale(prescale), .dur_flat(dur_flat), .pattern_flat(pattern_flat),
      .last_phase(last_phase), .repeats(repeats),
      .busy(busy), .phase(phase), .out_pattern(out_pattern),
      .phase_strobe(phase_strobe), .done(done), .passes_done(passes_done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint plen(input int k);
      longint d;
      d = (m_dur[k] == 0) ? 64'd1 : m_dur[k];
      return d * (m_pre + 1);
   endfunction

   // Advance the model by one clock using the inputs present at the coming edge.
   task automatic model_update();
      m_strobe = 1'b0;
      m_done   = 1'b0;
      if (!rstn) begin
         m_busy = 1'b0; m_phase = 0; m_passes = 0;
      end else if (abort) begin
         m_busy = 1'b0; m_phase = 0;
      end else if (!m_busy) begin
         if (start) begin
            m_pre  = int'(prescale);
            m_last = int'(last_phase);
            m_rep  = int'(repeats);
            for (int k = 0; k < 4; k++) begin
               m_dur[k] = longint'(dur_flat[k*32 +: 32]);
               m_pat[k] = pattern_flat[k*8 +: 8];
            end
            m_busy = 1'b1; m_phase = 0; m_passes = 0;
            m_left = plen(0); m_strobe = 1'b1;
         end
      end else if (m_left > 1) begin
         m_left--;
      end else if (m_phase != m_last) begin
         m_phase++;
         m_left = plen(m_phase);
         m_strobe = 1'b1;
      end else begin
         if (m_passes < 65535) m_passes++;
         if (m_rep == 0 || m_passes < m_rep) begin
            m_phase = 0; m_left = plen(0); m_strobe = 1'b1;
         end else begin
            m_busy = 1'b0; m_phase = 0; m_done = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      chk("busy", 64'(busy), 64'(m_busy));
      chk("phase", 64'(phase), 64'(m_phase));
      chk("out_pattern", 64'(out_pattern), m_busy ? 64'(m_pat[m_phase]) : 64'd0);
      chk("phase_strobe", 64'(phase_strobe), 64'(m_strobe));
      chk("done", 64'(done), 64'(m_done));
      chk("passes_done", 64'(passes_done), 64'(m_passes));
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic set_cfg(input int pre, input int last, input int rep,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3,
                          input logic [7:0] p0, input logic [7:0] p1,
                          input logic [7:0] p2, input logic [7:0] p3);
      prescale     = 16'(pre);
      last_phase   = 2'(last);
      repeats      = 16'(rep);
      dur_flat     = {d3, d2, d1, d0};
      pattern_flat = {p3, p2, p1, p0};
   endtask

   // Pulse start for one cycle then run n cycles, counting busy cycles and the done cycle.
   task automatic run_seq(input int n, output int busy_cnt, output int done_at);
      busy_cnt = 0;
      done_at  = -1;
      start = 1'b1;
      for (int i = 1; i <= n; i++) begin
         step();
         start = 1'b0;
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1 && done_at < 0) done_at = i;
      end
   endtask

   initial begin
      int bc;
      int da;
      int waited;
      rstn = 1'b0; start = 1'b0; abort = 1'b0;
      set_cfg(0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 8'h00, 8'h00, 8'h00, 8'h00);
      m_busy = 1'b0; m_phase = 0; m_passes = 0; m_left = 0; m_pre = 0; m_last = 0; m_rep = 0;
      for (int k = 0; k < 4; k++) begin m_dur[k] = 0; m_pat[k] = 8'h00; end
      step();
      step();
      rstn = 1'b1;
      step();

      // basic timing
      set_cfg(0, 2, 1, 32'd3, 32'd1, 32'd2, 32'd0, 8'h01, 8'h02, 8'h04, 8'h00);
      run_seq(9, bc, da);
      chk("basic_busy_cycles", 64'(bc), 64'd6);
      chk("basic_done_cycle", 64'(da), 64'd7);

      // prescaler and zero duration
      set_cfg(3, 1, 2, 32'd0, 32'd2, 32'd0, 32'd0, 8'hA5, 8'h5A, 8'h00, 8'h00);
      run_seq(27, bc, da);
      chk("presc_busy_cycles", 64'(bc), 64'd24);
      chk("presc_done_cycle", 64'(da), 64'd25);
      chk("presc_passes", 64'(passes_done), 64'd2);

      // infinite repeat, abort together with start
      set_cfg(0, 0, 0, 32'd5, 32'd0, 32'd0, 32'd0, 8'h3C, 8'h00, 8'h00, 8'h00);
      run_seq(51, bc, da);
      chk("inf_passes_at_abort", 64'(passes_done), 64'd10);
      abort = 1'b1; start = 1'b1;
      step();
      abort = 1'b0; start = 1'b0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_no_done", 64'(done), 64'd0);
      chk("abort_passes_hold", 64'(passes_done), 64'd10);
      for (int i = 0; i < 4; i++) step();

      // config isolation: change config and pulse start mid-run
      set_cfg(1, 3, 1, 32'd2, 32'd3, 32'd1, 32'd2, 8'h11, 8'h22, 8'h44, 8'h88);
      run_seq(6, bc, da);
      dur_flat = {$urandom, $urandom, $urandom, $urandom};
      pattern_flat = $urandom;
      start = 1'b1;
      step();
      start = 1'b0;
      if (busy === 1'b1) bc++;
      for (int i = 0; i < 14; i++) begin
         step();
         if (busy === 1'b1) bc++;
      end
      chk("iso_busy_cycles", 64'(bc), 64'd16);

      // back-to-back: start in the done cycle
      set_cfg(0, 1, 1, 32'd2, 32'd2, 32'd0, 32'd0, 8'h0F, 8'hF0, 8'h00, 8'h00);
      run_seq(1, bc, da);
      waited = 0;
      while (done !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      chk("b2b_done_seen", 64'(done), 64'd1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("b2b_strobe", 64'(phase_strobe), 64'd1);
      chk("b2b_busy", 64'(busy), 64'd1);
      chk("b2b_passes", 64'(passes_done), 64'd0);
      for (int i = 0; i < 6; i++) step();

      // asynchronous reset mid-run
      set_cfg(0, 3, 0, 32'd4, 32'd4, 32'd4, 32'd4, 8'h81, 8'h42, 8'h24, 8'h18);
      run_seq(6, bc, da);
      rstn = 1'b0;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_phase", 64'(phase), 64'd0);
      chk("rst_pattern", 64'(out_pattern), 64'd0);
      chk("rst_strobe", 64'(phase_strobe), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_passes", 64'(passes_done), 64'd0);
      m_busy = 1'b0; m_phase = 0; m_passes = 0; m_strobe = 1'b0; m_done = 1'b0;
      step();
      rstn = 1'b1;
      for (int i = 0; i < 5; i++) step();

      // randomized sequences with sporadic start/abort pulses
      for (int s = 0; s < 25; s++) begin
         set_cfg(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 32'($urandom_range(0, 4)), 32'($urandom_range(0, 4)),
                 32'($urandom_range(0, 4)), 32'($urandom_range(0, 4)),
                 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         run_seq(1, bc, da);
         for (int i = 0; i < 60; i++) begin
            abort = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) dur_flat[31:0] = 32'($urandom_range(0, 4));
            step();
         end
         abort = 1'b1; start = 1'b0;
         step();
         abort = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
- Multi-phase pulse scheduler: steps a single shared countdown timer through up to NPHASE programmed durations, drives a per-phase output pattern and repeats the sequence a programmed number of times.
- Sits between the configuration registers and the trigger/gate logic. It replaces ad-hoc chaining of standalone countdown timers.
- The countdown timer and tick prescaler are internal to this block.

Parameters:
- NPHASE, 4, number of phase slots; the phase index is 2 bits wide.
- CW, 32, width of the duration and countdown fields.
- PW, 16, width of the prescaler.
- OW, 8, width of the output pattern per phase.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  start request, sampled only in IDLE.
- abort  in  1  synchronous abort; has priority over start.
- prescale  in  PW  tick period minus 1 (0 = tick every clk).
- dur_flat  in  NPHASE*CW  phase k duration in ticks, held in bits [k*CW +: CW].
- pattern_flat  in  NPHASE*OW  phase k output pattern, held in bits [k*OW +: OW].
- last_phase  in  2  index of the final phase used (0..NPHASE-1).
- repeats  in  16  number of sequence passes (0 = infinite).
- busy  out  1  high while a sequence is running.
- phase  out  2  current phase index.
- out_pattern  out  OW  pattern of the current phase; 0 when idle.
- phase_strobe  out  1  one-cycle pulse on the first cycle of every phase.
- done  out  1  one-cycle pulse when the final pass completes.
- passes_done  out  16  completed passes; saturates at 0xFFFF; cleared at start.

Behaviour:
- Async reset (rstn=0): state goes to IDLE. busy, phase, out_pattern, phase_strobe, done, passes_done, timer and prescaler all become 0.
- States: IDLE, RUN.
- Config latch: prescale, dur_flat, pattern_flat, last_phase and repeats are latched on the start edge. Input changes during RUN have no effect until the next start.
- IDLE -> RUN: start=1 and abort=0 in cycle N. In cycle N+1:
  - busy=1, phase=0, out_pattern=pattern[0], phase_strobe=1.
  - passes_done=0, prescaler=0.
  - timer=max(dur[0],1).
- Prescaler: pre_cnt counts 0..P, where P is the latched prescale. tick is asserted when pre_cnt==P, and pre_cnt then wraps to 0. pre_cnt restarts from 0 at every phase entry.
- Timer: on tick, if timer>1 then timer decrements. On tick with timer==1 the phase ends.
- Phase length is exactly max(dur_k,1)*(P+1) clk cycles. dur=0 is treated as 1.
- Phase end, not the last phase: in the next cycle phase increments and timer=max(dur[phase+1],1). out_pattern updates and phase_strobe pulses. There is no gap cycle between phases.
- Phase end, last phase (phase==last_phase):
  - passes_done increments, saturating at 0xFFFF.
  - If repeats==0, or the new passes_done is less than repeats: wrap to phase 0 with a strobe and no gap.
  - Otherwise go to IDLE. In the next cycle busy=0, phase=0, out_pattern=0, done=1 for one cycle. passes_done holds its value.
- With repeats==0 the sequence runs until abort; passes_done saturates and does not wrap.
- Abort: abort=1 in any state at cycle N gives IDLE at N+1. busy, phase and out_pattern become 0, with no done pulse; passes_done holds.
  - abort=1 and start=1 together: abort wins and the block stays IDLE.
- start while busy is ignored; it causes no restart and no config relatch.
- A start arriving in the same cycle that done is asserted is accepted, because the block is already IDLE: a new sequence begins the next cycle.
- The phase index never exceeds last_phase.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: hold rstn=0 mid-RUN -> all outputs 0 immediately (asynchronously). Release rstn -> block is IDLE and ignores the stale config.
- Basic timing: prescale=0, last_phase=2, dur={3,1,2}, patterns={0x01,0x02,0x04}, repeats=1, start at cycle 0. Required response:
  - busy is high cycles 1..6.
  - out_pattern is 0x01 for cycles 1-3, 0x02 for cycle 4 and 0x04 for cycles 5-6.
  - phase_strobe fires at cycles 1, 4 and 5.
  - done=1 at cycle 7, with passes_done=1.
- Prescaler and zero duration: prescale=3, last_phase=1, dur={0,2}, repeats=2. Required response:
  - Phase 0 lasts 4 cycles and phase 1 lasts 8 cycles; total 24 cycles of busy.
  - done fires one cycle after the last phase ends, with passes_done=2.
- Infinite repeat with abort: repeats=0, last_phase=0, dur={5}, run for 50 cycles, then assert abort together with start. Required response:
  - passes_done=10 at abort.
  - Next cycle busy=0 and out_pattern=0, with no done pulse.
  - The block stays IDLE.
- Config isolation: change dur_flat and pattern_flat mid-sequence, and pulse start while busy. Required response: the current sequence's timing and patterns are unchanged, and no restart occurs.
- Back-to-back: assert start in the done cycle -> the new sequence begins the next cycle with phase_strobe=1 and passes_done=0.
